dw_data_sync_rx: RTL

Destination-domain receive buffer for the data-synchronizer path. It sits directly behind a data synchronizer's destination side. Each single-cycle `data_avail_d` strobe is captured with its `data_d` word into a small first-word-fall-through FIFO, which is presented to local logic over a valid/pop interface. Overflow is detected, flagged and counted, so that strobes arriving faster than the consumer drains them are never silently lost.

---
 rtl/dw_data_sync_rx_pkg.sv | 19 +
 rtl/dw_data_sync_rx_ram.sv | 42 ++++
 rtl/dw_data_sync_rx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dw_data_sync_rx_pkg.sv
// Shared constants and types for the data-synchronizer receive buffer.
package dw_data_sync_rx_pkg;

    localparam int OVF_DROP      = 0;
    localparam int OVF_OVERWRITE = 1;
    localparam int DROP_MAX      = 255;

    typedef struct packed {
        logic push;
        logic pop;
        logic ovf;
        logic rd_adv;
    } fifo_ev_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dw_data_sync_rx_ram.sv
// Register-array storage: one write port, one async read port, sync clear.
module dw_data_sync_rx_ram #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     we,
    input  logic [$clog2(depth)-1:0] waddr,
    input  logic [width-1:0]         wdata,
    input  logic [$clog2(depth)-1:0] raddr,
    output logic [width-1:0]         rdata
);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];

    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            for (int i = 0; i < depth; i++) begin
                mem_d[i] = '0;
            end
        end else if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dw_data_sync_rx.sv
// Destination-side FWFT receive buffer with overflow flag and drop counter.
module dw_data_sync_rx
    import dw_data_sync_rx_pkg::*;
#(
    parameter int width    = 8,
    parameter int depth    = 4,
    parameter int ovf_mode = 0
) (
    input  logic                      clk_d,
    input  logic                      rst_d,
    input  logic                      init_d_n,
    input  logic                      data_avail_d,
    input  logic [width-1:0]          data_d,
    input  logic                      pop_d,
    output logic                      valid_d,
    output logic [width-1:0]          data_out,
    output logic [cnt_w(depth)-1:0]   count_d,
    output logic                      full_d,
    output logic                      overflow_d,
    output logic [7:0]                drop_cnt
);

    localparam int AW = $clog2(depth);
    localparam int CW = cnt_w(depth);
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);
    localparam logic [7:0] DROP_SAT = 8'(DROP_MAX);
    localparam bit OVR = (ovf_mode == OVF_OVERWRITE);

    if (depth < 2 || depth > 16 || (depth & (depth - 1)) != 0) begin : g_bad_depth
        $error("dw_data_sync_rx: depth must be a power of 2 in 2..16");
    end
    if (ovf_mode != OVF_DROP && ovf_mode != OVF_OVERWRITE) begin : g_bad_mode
        $error("dw_data_sync_rx: ovf_mode must be 0 or 1");
    end
    if (width < 1 || width > 1024) begin : g_bad_width
        $error("dw_data_sync_rx: width must be in 1..1024");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;
    logic          empty;
    logic          full;
    fifo_ev_t      ev;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);

    // A pop frees a slot on the same edge, so full+push+pop is not an overflow.
    always_comb begin
        ev        = '0;
        ev.pop    = pop_d && !empty;
        ev.ovf    = data_avail_d && full && !ev.pop;
        ev.push   = data_avail_d && (!full || ev.pop || OVR);
        ev.rd_adv = ev.pop || (ev.ovf && OVR);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (!init_d_n) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            drop_d   = '0;
        end else begin
            if (ev.push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (ev.rd_adv) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (ev.push && !ev.rd_adv) begin
                cnt_d = cnt_q + 1'b1;
            end else if (ev.rd_adv && !ev.push) begin
                cnt_d = cnt_q - 1'b1;
            end
            if (ev.ovf) begin
                ovf_d = 1'b1;
                if (drop_q != DROP_SAT) begin
                    drop_d = drop_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_d or posedge rst_d) begin
        if (rst_d) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    dw_data_sync_rx_ram #(
        .width (width),
        .depth (depth)
    ) u_ram (
        .clk   (clk_d),
        .rst   (rst_d),
        .clr   (!init_d_n),
        .we    (ev.push && init_d_n),
        .waddr (wr_ptr_q),
        .wdata (data_d),
        .raddr (rd_ptr_q),
        .rdata (data_out)
    );

    assign valid_d    = !empty;
    assign count_d    = cnt_q;
    assign full_d     = full;
    assign overflow_d = ovf_q;
    assign drop_cnt   = drop_q;

endmodule
